// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin arbiter: sizing constants and
// vector helpers, all working on a 32-bit carrier with a runtime width.
package rr_pkg;
  localparam int RR_N_DEFAULT = 4;
  localparam int RR_MAX_N     = 32;
  localparam int RR_IDX_W     = 5;

  typedef logic [RR_MAX_N-1:0] rr_vec_t;
  typedef logic [RR_IDX_W-1:0] rr_idx_t;

  // Index of the set bit in a one-hot vector; zero when no bit is set.
  function automatic rr_idx_t onehot_to_idx(input rr_vec_t v);
    rr_idx_t idx;
    idx = '0;
    for (int i = 0; i < RR_MAX_N; i++)
      if (v[i]) idx = idx | RR_IDX_W'(i);
    return idx;
  endfunction

  // Rotate the low w bits of v right by sh (sh < w); bits above w read as 0.
  function automatic rr_vec_t rotate_right(input rr_vec_t v, input int unsigned sh,
                                           input int unsigned w);
    rr_vec_t r;
    rr_idx_t src;
    r = '0;
    for (int unsigned i = 0; i < RR_MAX_N; i++) begin
      src = RR_IDX_W'((i + sh) % w);
      if (i < w) r[i] = v[src];
    end
    return r;
  endfunction

  function automatic rr_vec_t rotate_left(input rr_vec_t v, input int unsigned sh,
                                          input int unsigned w);
    rr_vec_t r;
    rr_idx_t src;
    r = '0;
    for (int unsigned i = 0; i < RR_MAX_N; i++) begin
      src = RR_IDX_W'((i + w - sh) % w);
      if (i < w) r[i] = v[src];
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating first-one finder: the requester at index ptr has
// highest priority, then ptr+1, wrapping modulo N.
module rr_priority_pick
  import rr_pkg::*;
#(
  parameter int N     = RR_N_DEFAULT,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick
);
  logic [N-1:0] rot;
  logic [N-1:0] low;

  always_comb begin
    rot  = N'(rotate_right(rr_vec_t'(req), 32'(ptr), N));
    // Two's-complement isolation keeps only the lowest set bit, so pick is one-hot or zero.
    low  = rot & (~rot + N'(1));
    pick = N'(rotate_left(rr_vec_t'(low), 32'(ptr), N));
  end
endmodule

// File: rtl/round_robin.sv
// Round-robin arbiter: registered one-hot grant, re-arbitrated every cycle,
// the winner drops to lowest priority on the following cycle.
module round_robin
  import rr_pkg::*;
#(
  parameter int N     = RR_N_DEFAULT,
  parameter int PTR_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [N-1:0]     pick;
  rr_idx_t          win;

  rr_priority_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick)
  );

  always_comb begin
    win = onehot_to_idx(rr_vec_t'(pick));
    if (win == RR_IDX_W'(N - 1)) ptr_next = '0;
    else                         ptr_next = PTR_W'(win + RR_IDX_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant <= '0;
      ptr   <= '0;
    end else if (|req) begin
      grant <= pick;
      ptr   <= ptr_next;
    end else begin
      // Idle cycle: drop the grant but keep the rotation position.
      grant <= '0;
    end
  end
endmodule

// File: tb/tb_round_robin.sv
// Bench for round_robin (N=4): directed scenarios plus randomized traffic
// against a search-order reference model.
module tb_round_robin;
  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] grant;

  int total = 0;
  int bad   = 0;

  int           mptr;
  logic [N-1:0] mgrant;

  round_robin #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk ptr, ptr+1, ... mod N; first requester wins.
  function automatic void model_arb(input logic [N-1:0] r);
    int i;
    mgrant = '0;
    for (int k = 0; k < N; k++) begin
      i = (mptr + k) % N;
      if (r[i]) begin
        mgrant[i] = 1'b1;
        mptr = (i + 1) % N;
        break;
      end
    end
  endfunction

  task automatic tick(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_arb(r);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    mptr   = 0;
    mgrant = '0;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    rst = 1'b0;
    #1;
    total++;
    if (grant !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async grant=%b want=0000", grant);
    end
    @(negedge clk);
    rst = 1'b1;
    mptr = 0;
    tick(4'b1111);
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first grant=%b want=0001", grant);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] rv [8];
    logic [N-1:0] ev [8];
    rv = '{4'b1000, 4'b1010, 4'b0010, 4'b0110, 4'b1110, 4'b1111, 4'b0100, 4'b0010};
    ev = '{4'b1000, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b0010};
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      tick(rv[k]);
      total++;
      if (grant !== ev[k]) begin
        bad++;
        $display("FAIL directed[%0d] req=%b grant=%b want=%b", k, rv[k], grant, ev[k]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] e;
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      tick(4'b1111);
      e = '0;
      e[k % N] = 1'b1;
      total++;
      if (grant !== e) begin
        bad++;
        $display("FAIL fairness[%0d] grant=%b want=%b", k, grant, e);
      end
    end
  endtask

  task automatic test_idle();
    reset_dut();
    tick(4'b1111);
    tick(4'b1111);
    tick(4'b0000);
    total++;
    if (grant !== 4'b0000) begin
      bad++;
      $display("FAIL idle_zero grant=%b want=0000", grant);
    end
    tick(4'b0000);
    tick(4'b1111);
    total++;
    if (grant !== 4'b0100) begin
      bad++;
      $display("FAIL idle_resume grant=%b want=0100", grant);
    end
    // Sole requester keeps winning even though it just held the grant.
    tick(4'b1000);
    tick(4'b1000);
    total++;
    if (grant !== 4'b1000) begin
      bad++;
      $display("FAIL sole_regrant grant=%b want=1000", grant);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    tick(4'b0100);
    total++;
    if (grant !== 4'b0100) begin
      bad++;
      $display("FAIL mid_pre grant=%b want=0100", grant);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (grant !== 4'b0000) begin
      bad++;
      $display("FAIL mid_async grant=%b want=0000", grant);
    end
    @(negedge clk);
    rst    = 1'b1;
    mptr   = 0;
    mgrant = '0;
    tick(4'b1111);
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL mid_ptr grant=%b want=0001", grant);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] flip;
    int wt [N];
    int err_model = 0, err_hot = 0, err_req = 0, err_wait = 0;
    reset_dut();
    r = '0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) flip[i] = ($urandom_range(3) == 0);
      r = r ^ flip;
      tick(r);
      if (grant !== mgrant) err_model++;
      if (!$onehot0(grant)) err_hot++;
      if ((grant & ~r) != '0) err_req++;
      for (int i = 0; i < N; i++) begin
        if (r[i] && !grant[i]) wt[i]++;
        else wt[i] = 0;
        if (wt[i] > N - 1) err_wait++;
      end
    end
    total++;
    if (err_model != 0) begin
      bad++;
      $display("FAIL rand_model cycles_wrong=%0d want=0", err_model);
    end
    total++;
    if (err_hot != 0) begin
      bad++;
      $display("FAIL rand_onehot cycles_wrong=%0d want=0", err_hot);
    end
    total++;
    if (err_req != 0) begin
      bad++;
      $display("FAIL rand_requested cycles_wrong=%0d want=0", err_req);
    end
    total++;
    if (err_wait != 0) begin
      bad++;
      $display("FAIL rand_starve waits_over=%0d want=0", err_wait);
    end
  endtask

  initial begin
    rst    = 1'b0;
    req    = '0;
    mptr   = 0;
    mgrant = '0;
    #3;
    test_reset();
    test_directed();
    test_fairness();
    test_idle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
